// File: rtl/bram_symbol_reader.sv
// rtl/bram_symbol_reader.sv - reads 2-bit symbols from a BRAM and packs 16 per word onto an AXI-Stream master
//
// Purpose: on a start pulse, read num_symbols consecutive symbols (clamped to
// 2^BRAM_BITDEPTH) starting at start_addr, wrapping at the top of the address
// space. Pack up to 16 symbols per 32-bit word and send each word with a
// tvalid/tready handshake. Pulse done once when the readout is finished.
//
// Ports:
//   m00_axis_aclk, m00_axis_areset   clock, asynchronous active-high reset
//   start, start_addr, num_symbols   readout request (start ignored unless idle)
//   busy, done                       status; done is a one-cycle pulse
//   bram_addr, bram_en, bram_douta   BRAM read port (fixed read latency)
//   m00_axis_t*                      output stream (tdata/tvalid/tready/tlast/tstrb)
`timescale 1ns/1ps
module bram_symbol_reader #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_BITDEPTH          = 16,
  parameter int BRAM_BITWIDTH          = 2,
  parameter int BRAM_READ_LATENCY      = 2
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_areset,
  input  logic                                start,
  input  logic [BRAM_BITDEPTH-1:0]            start_addr,
  input  logic [31:0]                         num_symbols,
  output logic                                busy,
  output logic                                done,
  output logic [BRAM_BITDEPTH-1:0]            bram_addr,
  output logic                                bram_en,
  input  logic [BRAM_BITWIDTH-1:0]            bram_douta,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int SYMS_PER_WORD = C_M00_AXIS_TDATA_WIDTH / BRAM_BITWIDTH;
  localparam int SYMS_PER_BYTE = 8 / BRAM_BITWIDTH;
  localparam int STRB_W        = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam int LAT           = BRAM_READ_LATENCY;

  localparam logic [32:0]              MAX_SYMS  = 33'd1 << BRAM_BITDEPTH;
  localparam logic [4:0]               LAST_SLOT = 5'(SYMS_PER_WORD - 1);
  localparam logic [BRAM_BITDEPTH-1:0] ADDR_ONE  = BRAM_BITDEPTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_SEND,
    S_FINISH
  } state_t;

  state_t                            state_q, state_d;
  logic [BRAM_BITDEPTH-1:0]          addr_q, addr_d;
  // symbols not yet issued to the BRAM; 33 bits so 2^32-1 and 2^16 both fit
  logic [32:0]                       remain_q, remain_d;
  logic [4:0]                        issued_q, issued_d;
  logic [4:0]                        captured_q, captured_d;
  logic [LAT-1:0]                    vld_q, vld_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_q, data_d;

  logic [32:0] req_syms;
  logic        cap_fire;
  logic [4:0]  captured_inc;

  assign req_syms     = ({1'b0, num_symbols} > MAX_SYMS) ? MAX_SYMS : {1'b0, num_symbols};
  // the oldest stage of the valid pipe lines up with bram_douta for that read
  assign cap_fire     = vld_q[LAT-1];
  assign captured_inc = captured_q + 5'd1;

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      issued_q   <= '0;
      captured_q <= '0;
      vld_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    data_d     = data_q;

    vld_d[0] = (state_q == S_FILL);
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // captures land in slot order, which matches issue order
    if (cap_fire) begin
      data_d[int'(captured_q[3:0]) * BRAM_BITWIDTH +: BRAM_BITWIDTH] = bram_douta;
      captured_d = captured_inc;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = start_addr;
          remain_d   = req_syms;
          issued_d   = '0;
          captured_d = '0;
          data_d     = '0;
          state_d    = (req_syms == 33'd0) ? S_FINISH : S_FILL;
        end
      end
      S_FILL: begin
        // address wraps naturally at the top of the BRAM
        addr_d   = addr_q + ADDR_ONE;
        remain_d = remain_q - 33'd1;
        issued_d = issued_q + 5'd1;
        if (remain_q == 33'd1 || issued_q == LAST_SLOT) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cap_fire && captured_inc == issued_q) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (m00_axis_tready) begin
          if (remain_q != 33'd0) begin
            issued_d   = '0;
            captured_d = '0;
            data_d     = '0;
            state_d    = S_FILL;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bram_en         = (state_q == S_FILL);
  assign bram_addr       = addr_q;
  assign busy            = (state_q == S_FILL) || (state_q == S_DRAIN) || (state_q == S_SEND);
  assign done            = (state_q == S_FINISH);
  assign m00_axis_tvalid = (state_q == S_SEND);
  assign m00_axis_tlast  = (state_q == S_SEND) && (remain_q == 33'd0);
  assign m00_axis_tdata  = data_q;

  // a byte strobe is set when the word holds a symbol in that byte; all ones outside SEND
  always_comb begin
    m00_axis_tstrb = '1;
    for (int b = 0; b < STRB_W; b++) begin
      m00_axis_tstrb[b] = (state_q != S_SEND) || (issued_q > 5'(b * SYMS_PER_BYTE));
    end
  end

endmodule

// File: doc/bram_symbol_reader.md
BRAM_SYMBOL_READER -- requirements
Module: bram_symbol_reader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- C_M00_AXIS_TDATA_WIDTH, 32, output stream width (fixed 32).
- BRAM_BITDEPTH, 16, BRAM address width.
- BRAM_BITWIDTH, 2, symbol width (fixed 2).
- BRAM_READ_LATENCY, 2, cycles from bram_addr/bram_en to valid bram_douta (1..4).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports (name, direction, width, meaning):
- m00_axis_aclk  in  1  sole clock.
- m00_axis_areset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a readout.
- start_addr  in  BRAM_BITDEPTH  first symbol address.
- num_symbols  in  32  symbols to read.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse when readout ends.
- bram_addr  out  BRAM_BITDEPTH  read address.
- bram_en  out  1  read enable.
- bram_douta  in  BRAM_BITWIDTH  read data.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  word valid.
- m00_axis_tlast  out  1  final word of readout.
- m00_axis_tdata  out  32  packed symbols.
- m00_axis_tstrb  out  4  byte strobes.

Function
REQ-003 The block SHALL implement the states IDLE, FILL, DRAIN, SEND and FINISH.
REQ-004 In IDLE, a start pulse SHALL latch start_addr and num_symbols, assert busy and enter FILL; if num_symbols==0 it SHALL go directly to FINISH and emit no word.
REQ-005 The block SHALL clamp num_symbols to 2^BRAM_BITDEPTH.
REQ-006 The block SHALL ignore start whenever it is not in IDLE.
REQ-007 In FILL, the block SHALL assert bram_en and issue one address per cycle, starting at start_addr and incrementing by 1 modulo 2^BRAM_BITDEPTH (address 2^BRAM_BITDEPTH-1 wraps to 0).
REQ-008 FILL SHALL issue at most 16 reads per word, or fewer if fewer symbols remain, then deassert bram_en and enter DRAIN.
REQ-009 A BRAM_READ_LATENCY-deep valid shift register SHALL capture bram_douta for every issued read exactly BRAM_READ_LATENCY cycles after issue.
REQ-010 Symbol k of a word (k = 0..15) SHALL be placed at tdata[2k+1:2k]; bits of unfilled slots SHALL be 0.
REQ-011 DRAIN SHALL end when all issued reads have been captured, then enter SEND with tvalid=1.
REQ-012 In SEND, tdata, tstrb and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-013 On a SEND handshake (tvalid & tready), the block SHALL return to FILL if symbols remain, else enter FINISH.
REQ-014 tstrb bit b SHALL be 1 iff byte b contains at least one valid symbol: full word 4'hF; a final word holding n symbols gives ceil(n/4) low-order ones.
REQ-015 tlast SHALL be 1 only on the word containing the final symbol.
REQ-016 FINISH SHALL pulse done for exactly one cycle, deassert busy in that same cycle and return to IDLE.
REQ-017 Remaining-symbol and word counters SHALL be at least 33 bits wide, so they do not overflow at 2^16 symbols.
REQ-018 The block SHALL never issue a read for a word until the previous word has handshaken; no skid buffer is required.

Reset
REQ-019 While m00_axis_areset=1, asynchronously and mid-operation included, the block SHALL force state=IDLE and:
- busy=0, done=0, bram_en=0, bram_addr=0
- tvalid=0, tlast=0, tdata=0, tstrb=4'hF
- all counters and the capture pipeline cleared
REQ-020 After reset deasserts, the block SHALL wait for a new start before issuing any read; it SHALL NOT resume an interrupted readout.

Verification
REQ-021 start_addr=1, num_symbols=16, BRAM[1..16]=0..3 repeating, tready=1 -> one word tdata=32'hE4E4E4E4, tstrb=4'hF, tlast=1, done one cycle after the handshake.
REQ-022 num_symbols=37 -> three words, third holds 5 symbols with tstrb=4'b0011 and upper 22 bits 0; tlast only on word 3.
REQ-023 start_addr=16'hFFFE, num_symbols=4 -> reads from addresses FFFE, FFFF, 0000, 0001 in that order.
REQ-024 tready held 0 for 10 cycles during SEND -> tdata, tstrb and tlast are constant, no further bram_en, and the word transfers once tready rises.
REQ-025 Reset asserted mid-FILL of a 100-symbol readout -> all outputs take their reset values immediately, and no done pulse follows.
REQ-026 num_symbols=0 -> no tvalid, done pulses once; a second start while busy during a 64-symbol run -> ignored, exactly 4 words emitted.
